// File: rtl/ball_speed_ctrl_pkg.sv
// Shared ball definitions: speed/counter widths and the rally FSM state encoding.
// Reused by the ball clock divider and the game FSM.
package ball_speed_ctrl_pkg;

  localparam int unsigned SPEED_W = 26;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned HITS_W  = 8;
  localparam int unsigned SUB_W   = 4;

  // Encoding is fixed; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RALLY = 2'd1,
    HOLD  = 2'd2,
    RSVD  = 2'd3
  } state_e;

endpackage

// File: rtl/ball_speed_ctrl_if.sv
// Game-logic <-> speed scheduler bus.
//  master (game logic): drives serve/paddle_hit/point_scored pulses, observes speed state.
//  slave  (scheduler) : receives pulses, drives ball_speed, speed_update, speed_level,
//                       rally_hits, in_play.
interface ball_speed_ctrl_if;
  import ball_speed_ctrl_pkg::*;

  logic               serve;
  logic               paddle_hit;
  logic               point_scored;
  logic [SPEED_W-1:0] ball_speed;
  logic               speed_update;
  logic [LEVEL_W-1:0] speed_level;
  logic [HITS_W-1:0]  rally_hits;
  logic               in_play;

  modport master (
    output serve, paddle_hit, point_scored,
    input  ball_speed, speed_update, speed_level, rally_hits, in_play
  );

  modport slave (
    input  serve, paddle_hit, point_scored,
    output ball_speed, speed_update, speed_level, rally_hits, in_play
  );

endinterface

// File: rtl/ball_speed_ctrl_step_calc.sv
// speed_step_calc: combinational next ball_speed for a level-up.
//  speed        : current ball_speed
//  next_speed_c : speed minus step, clamped to MIN_SPEED without borrow
//  changed_c    : next_speed_c differs from speed
// Macro SPEED_PCT_STEP_EN selects a proportional step (speed >> STEP_SHIFT)
// instead of the fixed SPEED_STEP.
module speed_step_calc
  import ball_speed_ctrl_pkg::*;
#(
  parameter logic [SPEED_W-1:0] SPEED_STEP = 26'd200_000,
  parameter logic [SPEED_W-1:0] MIN_SPEED  = 26'd500_000
`ifdef SPEED_PCT_STEP_EN
  ,
  parameter int unsigned        STEP_SHIFT = 3
`endif
) (
  input  logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] next_speed_c,
  output logic               changed_c
);

  logic [SPEED_W-1:0] step;
  logic [SPEED_W-1:0] headroom;

  // Step size; a proportional step of zero still has to move the ball.
  always_comb begin
`ifdef SPEED_PCT_STEP_EN
    step = speed >> STEP_SHIFT;
    if (step == '0) begin
      step = SPEED_W'(1);
    end
`else
    step = SPEED_STEP;
`endif
  end

  // Clamp against the distance to the floor so the subtraction never wraps.
  always_comb begin
    headroom     = (speed > MIN_SPEED) ? (speed - MIN_SPEED) : '0;
    next_speed_c = (step > headroom) ? MIN_SPEED : (speed - step);
    changed_c    = (next_speed_c != speed);
  end

endmodule

// File: rtl/ball_speed_ctrl.sv
// ball_speed_ctrl: rally speed scheduler feeding the ball clock divider.
//  clk_in : system clock
//  rst    : synchronous active-high reset
//  bus    : slave side of ball_speed_ctrl_if (serve/paddle_hit/point_scored in;
//           ball_speed, speed_update, speed_level, rally_hits, in_play out, all registered)
// Optional macro SPEED_PCT_STEP_EN: proportional level-up step (see speed_step_calc).
module ball_speed_ctrl
  import ball_speed_ctrl_pkg::*;
#(
  parameter logic [SPEED_W-1:0] SERVE_SPEED    = 26'd2_500_000,
  parameter logic [SPEED_W-1:0] SPEED_STEP     = 26'd200_000,
  parameter logic [SPEED_W-1:0] MIN_SPEED      = 26'd500_000,
  parameter int unsigned        HITS_PER_LEVEL = 4,
  parameter int unsigned        MAX_LEVEL      = 15,
  parameter logic [SPEED_W-1:0] HOLD_CYC       = 26'd50_000_000
`ifdef SPEED_PCT_STEP_EN
  ,
  parameter int unsigned        STEP_SHIFT     = 3
`endif
) (
  input  logic               clk_in,
  input  logic               rst,
  ball_speed_ctrl_if.slave   bus
);

  state_e             state, state_nxt;
  logic [SPEED_W-1:0] speed_q, speed_nxt;
  logic               upd_q, upd_nxt;
  logic [LEVEL_W-1:0] level_q, level_nxt;
  logic [HITS_W-1:0]  hits_q, hits_nxt;
  logic [SUB_W-1:0]   sub_q, sub_nxt;
  logic [SPEED_W-1:0] hold_q, hold_nxt;
  logic               in_play_q, in_play_nxt;

  logic [SPEED_W-1:0] step_speed_c;
  logic               step_changed_c;

  speed_step_calc #(
    .SPEED_STEP (SPEED_STEP),
    .MIN_SPEED  (MIN_SPEED)
`ifdef SPEED_PCT_STEP_EN
    ,
    .STEP_SHIFT (STEP_SHIFT)
`endif
  ) u_step (
    .speed        (speed_q),
    .next_speed_c (step_speed_c),
    .changed_c    (step_changed_c)
  );

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      speed_q   <= SERVE_SPEED;
      upd_q     <= 1'b0;
      level_q   <= '0;
      hits_q    <= '0;
      sub_q     <= '0;
      hold_q    <= '0;
      in_play_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      speed_q   <= speed_nxt;
      upd_q     <= upd_nxt;
      level_q   <= level_nxt;
      hits_q    <= hits_nxt;
      sub_q     <= sub_nxt;
      hold_q    <= hold_nxt;
      in_play_q <= in_play_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    speed_nxt = speed_q;
    upd_nxt   = 1'b0;
    level_nxt = level_q;
    hits_nxt  = hits_q;
    sub_nxt   = sub_q;
    hold_nxt  = hold_q;

    case (state)
      IDLE: begin
        if (bus.serve) begin
          state_nxt = RALLY;
          hits_nxt  = '0;
          level_nxt = '0;
          sub_nxt   = '0;
        end
      end
      RALLY: begin
        // A point in the same cycle as a hit discards the hit.
        if (bus.point_scored) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end else if (bus.paddle_hit) begin
          if (hits_q != {HITS_W{1'b1}}) begin
            hits_nxt = hits_q + HITS_W'(1);
          end
          if (sub_q == SUB_W'(HITS_PER_LEVEL - 1)) begin
            sub_nxt = '0;
            // At the floor the hit still counts but nothing else moves.
            if (step_changed_c) begin
              speed_nxt = step_speed_c;
              upd_nxt   = 1'b1;
              if (level_q != LEVEL_W'(MAX_LEVEL)) begin
                level_nxt = level_q + LEVEL_W'(1);
              end
            end
          end else begin
            sub_nxt = sub_q + SUB_W'(1);
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_CYC - SPEED_W'(1)) begin
          state_nxt = IDLE;
          speed_nxt = SERVE_SPEED;
          upd_nxt   = (speed_q != SERVE_SPEED);
        end else begin
          hold_nxt = hold_q + SPEED_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        speed_nxt = SERVE_SPEED;
        upd_nxt   = (speed_q != SERVE_SPEED);
      end
    endcase

    in_play_nxt = (state_nxt == RALLY);
  end

  assign bus.ball_speed   = speed_q;
  assign bus.speed_update = upd_q;
  assign bus.speed_level  = level_q;
  assign bus.rally_hits   = hits_q;
  assign bus.in_play      = in_play_q;

endmodule
